// File: rtl/motor_move_sequencer.sv
// motor_move_sequencer
//   Front end for the X/Y stepper controllers of the klotski gantry. Takes one piece-move
//   command (axis, direction, cells) over a valid/ready handshake. It converts cells to
//   motor steps, pulses the selected axis enable for one cycle and waits for that axis'
//   done pulse. It then waits out a mechanical settle time and pulses o_move_done.
//   A watchdog flags a motor that never reports done.
// Ports
//   i_Clk, i_rst_n                  clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready       command handshake
//   i_cmd_axis, i_cmd_dir, i_cmd_cells  command payload (0 = X, 1 = Y; cells 0..15)
//   o_x_en/o_x_dir/o_x_steps/i_x_done   X motor controller interface
//   o_y_en/o_y_dir/o_y_steps/i_y_done   Y motor controller interface
//   o_busy        high whenever not idle
//   o_move_done   one-cycle completion pulse
//   o_error       sticky watchdog flag, cleared by i_clr_err
module motor_move_sequencer #(
  parameter int unsigned STEPS_PER_CELL = 200,
  parameter int unsigned SETTLE_CYCLES  = 5000000,
  parameter int unsigned TIMEOUT_CYCLES = 2**30
) (
  input  logic        i_Clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_axis,
  input  logic        i_cmd_dir,
  input  logic [3:0]  i_cmd_cells,
  output logic        o_x_en,
  output logic        o_x_dir,
  output logic [31:0] o_x_steps,
  input  logic        i_x_done,
  output logic        o_y_en,
  output logic        o_y_dir,
  output logic [31:0] o_y_steps,
  input  logic        i_y_done,
  output logic        o_busy,
  output logic        o_move_done,
  output logic        o_error,
  input  logic        i_clr_err
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StSettle, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        axis_q, axis_d;

  logic        ready_q, ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        x_en_q, x_en_d, y_en_q, y_en_d;
  logic        x_dir_q, x_dir_d, y_dir_q, y_dir_d;
  logic [31:0] x_steps_q, x_steps_d, y_steps_q, y_steps_d;

  logic        accept;
  logic        issue;
  logic        sel_done;
  logic        settle_end;
  logic [31:0] steps_calc;

  // ready_q is the registered ready, so the first cycle after reset cannot accept.
  assign accept     = (state_q == StIdle) && i_cmd_valid && ready_q;
  assign issue      = accept && (i_cmd_cells != 4'd0);
  assign sel_done   = axis_q ? i_y_done : i_x_done;
  assign steps_calc = 32'(i_cmd_cells) * STEPS_PER_CELL;
  assign settle_end = (SETTLE_CYCLES == 0) || (cnt_q == SETTLE_CYCLES - 1);

  // State register
  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      axis_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      axis_q  <= axis_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    axis_d  = accept ? i_cmd_axis : axis_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = issue ? StIssue : StDone;
      end
      StIssue:  state_d = StWait;
      StWait: begin
        // A done arriving on the watchdog's last cycle still counts as success.
        if (sel_done)                           state_d = StSettle;
        else if (cnt_q == TIMEOUT_CYCLES - 1)   state_d = StErr;
      end
      StSettle: begin
        if (settle_end) state_d = StDone;
      end
      StDone:   state_d = StIdle;
      StErr: begin
        if (i_clr_err) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase

    // Counter only runs while staying in WAIT or SETTLE; any entry restarts it at zero.
    cnt_d = '0;
    if ((state_q == StWait || state_q == StSettle) && state_d == state_q) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Output logic, computed from the next state so every output is a flop.
  always_comb begin
    ready_d   = (state_d == StIdle);
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StDone);
    error_d   = (state_d == StErr);
    x_en_d    = (state_d == StIssue) && !axis_d;
    y_en_d    = (state_d == StIssue) && axis_d;
    x_dir_d   = x_dir_q;
    x_steps_d = x_steps_q;
    y_dir_d   = y_dir_q;
    y_steps_d = y_steps_q;
    if (issue && !i_cmd_axis) begin
      x_dir_d   = i_cmd_dir;
      x_steps_d = steps_calc;
    end
    if (issue && i_cmd_axis) begin
      y_dir_d   = i_cmd_dir;
      y_steps_d = steps_calc;
    end
  end

  always_ff @(posedge i_Clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      x_en_q    <= 1'b0;
      y_en_q    <= 1'b0;
      x_dir_q   <= 1'b0;
      y_dir_q   <= 1'b0;
      x_steps_q <= '0;
      y_steps_q <= '0;
    end else begin
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      x_en_q    <= x_en_d;
      y_en_q    <= y_en_d;
      x_dir_q   <= x_dir_d;
      y_dir_q   <= y_dir_d;
      x_steps_q <= x_steps_d;
      y_steps_q <= y_steps_d;
    end
  end

  assign o_cmd_ready = ready_q;
  assign o_busy      = busy_q;
  assign o_move_done = done_q;
  assign o_error     = error_q;
  assign o_x_en      = x_en_q;
  assign o_y_en      = y_en_q;
  assign o_x_dir     = x_dir_q;
  assign o_y_dir     = y_dir_q;
  assign o_x_steps   = x_steps_q;
  assign o_y_steps   = y_steps_q;

endmodule

// File: tb/tb_motor_move_sequencer.sv
module tb_motor_move_sequencer;

  logic        i_Clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic        i_cmd_axis = 1'b0;
  logic        i_cmd_dir = 1'b0;
  logic [3:0]  i_cmd_cells = 4'd0;
  logic        o_x_en, o_x_dir, o_y_en, o_y_dir;
  logic [31:0] o_x_steps, o_y_steps;
  logic        i_x_done = 1'b0;
  logic        i_y_done = 1'b0;
  logic        o_busy, o_move_done, o_error;
  logic        i_clr_err = 1'b0;

  int checks = 0;
  int errors = 0;
  logic overlap = 1'b0;

  motor_move_sequencer #(
    .STEPS_PER_CELL(200),
    .SETTLE_CYCLES (4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .i_Clk      (i_Clk),
    .i_rst_n    (i_rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_axis (i_cmd_axis),
    .i_cmd_dir  (i_cmd_dir),
    .i_cmd_cells(i_cmd_cells),
    .o_x_en     (o_x_en),
    .o_x_dir    (o_x_dir),
    .o_x_steps  (o_x_steps),
    .i_x_done   (i_x_done),
    .o_y_en     (o_y_en),
    .o_y_dir    (o_y_dir),
    .o_y_steps  (o_y_steps),
    .i_y_done   (i_y_done),
    .o_busy     (o_busy),
    .o_move_done(o_move_done),
    .o_error    (o_error),
    .i_clr_err  (i_clr_err)
  );

  always #5 i_Clk = ~i_Clk;

  always @(negedge i_Clk) if (o_x_en && o_y_en) overlap = 1'b1;

  task automatic tick();
    @(posedge i_Clk);
    #1;
  endtask

  task automatic send(input logic axis, input logic dir, input logic [3:0] cells);
    i_cmd_axis  = axis;
    i_cmd_dir   = dir;
    i_cmd_cells = cells;
    i_cmd_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [71:0] all_out;
    repeat (3) tick();
    all_out = {o_cmd_ready, o_x_en, o_x_dir, o_x_steps, o_y_en, o_y_dir, o_y_steps,
               o_busy, o_move_done, o_error};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", all_out);
    end
    i_rst_n = 1'b1;
    checks++;
    if (o_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_release: got %b want 0", o_cmd_ready);
    end
    tick();
    checks++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_ready_rise: ready %b busy %b want 1 0", o_cmd_ready, o_busy);
    end
  endtask

  task automatic test_x_move();
    logic bad;
    send(1'b0, 1'b1, 4'd3);
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_x_en !== 1'b1 || o_x_steps !== 32'd600 || o_x_dir !== 1'b1 || o_y_en !== 1'b0) begin
      errors++; $display("FAIL x_issue: en %b steps %0d dir %b y_en %b want 1 600 1 0",
                         o_x_en, o_x_steps, o_x_dir, o_y_en);
    end
    checks++;
    if (o_cmd_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL x_busy: ready %b busy %b want 0 1", o_cmd_ready, o_busy);
    end
    tick();
    bad = 1'b0;
    repeat (48) begin
      if (o_x_en || o_y_en || o_move_done || o_error) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL x_wait_quiet: got %b want 0", bad);
    end
    i_x_done = 1'b1;
    tick();
    i_x_done = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      if (o_move_done !== 1'b0) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0 || o_move_done !== 1'b1) begin
      errors++; $display("FAIL x_settle: early %b done %b want 0 1", bad, o_move_done);
    end
    tick();
    checks++;
    if (o_move_done !== 1'b0 || o_cmd_ready !== 1'b1 || o_busy !== 1'b0 ||
        o_x_steps !== 32'd600 || o_x_dir !== 1'b1) begin
      errors++; $display("FAIL x_after: done %b ready %b busy %b steps %0d dir %b want 0 1 0 600 1",
                         o_move_done, o_cmd_ready, o_busy, o_x_steps, o_x_dir);
    end
  endtask

  task automatic test_zero_move();
    send(1'b1, 1'b0, 4'd0);
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_move_done !== 1'b1 || o_x_en !== 1'b0 || o_y_en !== 1'b0 || o_y_steps !== 32'd0) begin
      errors++; $display("FAIL zero_done: done %b x_en %b y_en %b y_steps %0d want 1 0 0 0",
                         o_move_done, o_x_en, o_y_en, o_y_steps);
    end
    tick();
    checks++;
    if (o_move_done !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL zero_after: done %b ready %b want 0 1", o_move_done, o_cmd_ready);
    end
  endtask

  task automatic test_wrong_axis();
    logic bad;
    send(1'b1, 1'b0, 4'd2);
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_y_en !== 1'b1 || o_y_steps !== 32'd400 || o_y_dir !== 1'b0 || o_x_en !== 1'b0 ||
        o_x_steps !== 32'd600 || o_x_dir !== 1'b1) begin
      errors++; $display("FAIL y_issue: y %b %0d %b x %b %0d %b want 1 400 0 0 600 1",
                         o_y_en, o_y_steps, o_y_dir, o_x_en, o_x_steps, o_x_dir);
    end
    repeat (5) tick();
    i_x_done = 1'b1;
    tick();
    i_x_done = 1'b0;
    bad = 1'b0;
    repeat (10) begin
      if (o_move_done || !o_busy || o_error) bad = 1'b1;
      tick();
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL wrong_axis_ignored: got %b want 0", bad);
    end
    i_y_done = 1'b1;
    tick();
    i_y_done = 1'b0;
    repeat (4) tick();
    checks++;
    if (o_move_done !== 1'b1) begin
      errors++; $display("FAIL wrong_axis_complete: got %b want 1", o_move_done);
    end
    tick();
  endtask

  task automatic test_timeout();
    logic bad;
    logic found;
    send(1'b0, 1'b0, 4'd1);
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_x_en !== 1'b1 || o_x_steps !== 32'd200 || o_x_dir !== 1'b0) begin
      errors++; $display("FAIL to_issue: en %b steps %0d dir %b want 1 200 0",
                         o_x_en, o_x_steps, o_x_dir);
    end
    bad = 1'b0;
    repeat (100) begin
      tick();
      if (o_error) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL to_early: got %b want 0", bad);
    end
    tick();
    checks++;
    if (o_error !== 1'b1 || o_cmd_ready !== 1'b0 || o_busy !== 1'b1) begin
      errors++; $display("FAIL to_error: err %b ready %b busy %b want 1 0 1",
                         o_error, o_cmd_ready, o_busy);
    end
    send(1'b1, 1'b1, 4'd1);
    bad = 1'b0;
    repeat (5) begin
      tick();
      if (o_cmd_ready || o_x_en || o_y_en || !o_error) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL to_sticky: got %b want 0", bad);
    end
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    checks++;
    if (o_error !== 1'b0 || o_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL to_clear: err %b ready %b want 0 1", o_error, o_cmd_ready);
    end
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_y_en !== 1'b1 || o_y_steps !== 32'd200 || o_y_dir !== 1'b1) begin
      errors++; $display("FAIL to_new_cmd: en %b steps %0d dir %b want 1 200 1",
                         o_y_en, o_y_steps, o_y_dir);
    end
    tick();
    i_y_done = 1'b1;
    tick();
    i_y_done = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (o_move_done) found = 1'b1;
      else tick();
    end
    checks++;
    if (found !== 1'b1) begin
      errors++; $display("FAIL to_new_done: got %b want 1", found);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    send(1'b0, 1'b0, 4'd1);
    tick();
    checks++;
    if (o_x_en !== 1'b1) begin
      errors++; $display("FAIL b2b_first_en: got %b want 1", o_x_en);
    end
    send(1'b1, 1'b1, 4'd2);
    tick();
    tick();
    i_x_done = 1'b1;
    tick();
    i_x_done = 1'b0;
    repeat (4) tick();
    checks++;
    if (o_move_done !== 1'b1 || o_cmd_ready !== 1'b0 || o_y_en !== 1'b0) begin
      errors++; $display("FAIL b2b_first_done: done %b ready %b y_en %b want 1 0 0",
                         o_move_done, o_cmd_ready, o_y_en);
    end
    tick();
    checks++;
    if (o_cmd_ready !== 1'b1 || o_y_en !== 1'b0 || o_move_done !== 1'b0) begin
      errors++; $display("FAIL b2b_ready: ready %b y_en %b done %b want 1 0 0",
                         o_cmd_ready, o_y_en, o_move_done);
    end
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_y_en !== 1'b1 || o_x_en !== 1'b0 || o_y_steps !== 32'd400 || o_y_dir !== 1'b1 ||
        o_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_second_en: y %b x %b steps %0d dir %b ready %b want 1 0 400 1 0",
                         o_y_en, o_x_en, o_y_steps, o_y_dir, o_cmd_ready);
    end
    tick();
    i_y_done = 1'b1;
    tick();
    i_y_done = 1'b0;
    repeat (4) tick();
    checks++;
    if (o_move_done !== 1'b1) begin
      errors++; $display("FAIL b2b_second_done: got %b want 1", o_move_done);
    end
    tick();
    checks++;
    if (overlap !== 1'b0) begin
      errors++; $display("FAIL en_overlap: got %b want 0", overlap);
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] all_out;
    send(1'b0, 1'b1, 4'd15);
    tick();
    i_cmd_valid = 1'b0;
    checks++;
    if (o_x_en !== 1'b1 || o_x_steps !== 32'd3000) begin
      errors++; $display("FAIL rst_mid_issue: en %b steps %0d want 1 3000", o_x_en, o_x_steps);
    end
    tick();
    tick();
    #3 i_rst_n = 1'b0;
    #1;
    all_out = {o_cmd_ready, o_x_en, o_x_dir, o_x_steps, o_y_en, o_y_dir, o_y_steps,
               o_busy, o_move_done, o_error};
    checks++;
    if (all_out !== '0) begin
      errors++; $display("FAIL rst_mid_outputs: got %h want 0", all_out);
    end
    tick();
    #3 i_rst_n = 1'b1;
    #1;
    checks++;
    if (o_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL rst_mid_release: got %b want 0", o_cmd_ready);
    end
    tick();
    checks++;
    if (o_cmd_ready !== 1'b1 || o_busy !== 1'b0 || o_x_steps !== 32'd0) begin
      errors++; $display("FAIL rst_mid_ready: ready %b busy %b steps %0d want 1 0 0",
                         o_cmd_ready, o_busy, o_x_steps);
    end
  endtask

  initial begin
    test_reset();
    test_x_move();
    test_zero_move();
    test_wrong_axis();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
